// File: rtl/bp_cce_pkg.sv
// Shared CCE definitions used by the GPR write-port scheduler and its tag queue.
package bp_cce_pkg;

  localparam int bp_cce_inst_num_gpr   = 8;
  localparam int bp_cce_inst_gpr_width = 64;

  typedef enum logic {
    e_idle,
    e_wait
  } bp_cce_gpr_wr_sched_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO: one push port, one pop port, occupancy count.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [width_p-1:0]             data_i,
  input  logic                           yumi_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  output logic                           full_o,
  output logic [$clog2(els_p+1)-1:0]     count_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w-1:0]   cnt;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (v_i)    wr_ptr <= ptr_inc(wr_ptr);
      if (yumi_i) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({v_i, yumi_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count alone says which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (v_i) mem[wr_ptr] <= data_i;
  end

  assign data_o  = mem[rd_ptr];
  assign v_o     = (cnt != '0);
  assign full_o  = (cnt == cnt_w'(els_p));
  assign count_o = cnt;

endmodule

// File: rtl/bp_cce_gpr_wr_sched.sv
// Schedules the single GPR write port between immediate instruction writes and
// late directory-read results, with an in-order tag queue and GPR scoreboard.
module bp_cce_gpr_wr_sched
  import bp_cce_pkg::*;
#(
  parameter int num_gpr_p   = bp_cce_inst_num_gpr,
  parameter int gpr_width_p = bp_cce_inst_gpr_width,
  parameter int dir_tags_p  = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   inst_v_i,
  input  logic [num_gpr_p-1:0]   inst_gpr_w_i,
  input  logic [num_gpr_p-1:0]   inst_src_mask_i,
  input  logic                   inst_dir_rd_i,
  input  logic [num_gpr_p-1:0]   inst_dir_dst_i,
  input  logic [gpr_width_p-1:0] inst_data_i,
  output logic                   inst_ready_o,
  input  logic                   dir_v_i,
  input  logic [gpr_width_p-1:0] dir_data_i,
  output logic [num_gpr_p-1:0]   gpr_w_mask_o,
  output logic [gpr_width_p-1:0] gpr_w_data_o,
  output logic [num_gpr_p-1:0]   gpr_busy_o,
  output logic                   dir_idle_o,
  output logic                   err_o
);

  localparam int cnt_w = $clog2(dir_tags_p + 1);

  bp_cce_gpr_wr_sched_state_e state_r, state_n;

  logic [num_gpr_p-1:0] busy_r, head_tag, retire_mask, busy_eff;
  logic [cnt_w-1:0]     q_cnt;
  logic                 q_v, q_full, dir_pop, push, stall, err_r, err_set;

  bsg_fifo_1r1w_small #(
    .width_p (num_gpr_p),
    .els_p   (dir_tags_p)
  ) tag_q (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (push),
    .data_i  (inst_dir_dst_i),
    .yumi_i  (dir_pop),
    .v_o     (q_v),
    .data_o  (head_tag),
    .full_o  (q_full),
    .count_o (q_cnt)
  );

  // A retiring GPR is treated as free in the cycle its result is written.
  assign dir_pop     = dir_v_i & q_v;
  assign retire_mask = dir_pop ? head_tag : '0;
  assign busy_eff    = busy_r & ~retire_mask;

  assign stall = (dir_v_i & (|inst_gpr_w_i))
               | (|(inst_src_mask_i & busy_eff))
               | (|(inst_gpr_w_i & busy_eff))
               | (inst_dir_rd_i & (|(inst_dir_dst_i & busy_eff)))
               | (inst_dir_rd_i & q_full & ~dir_v_i);

  assign inst_ready_o = inst_v_i & ~stall;
  assign push         = inst_ready_o & inst_dir_rd_i;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    gpr_w_mask_o = '0;
    gpr_w_data_o = '0;
    if (dir_v_i) begin
      gpr_w_mask_o = retire_mask;
      gpr_w_data_o = dir_data_i;
    end else if (inst_ready_o) begin
      gpr_w_mask_o = inst_gpr_w_i;
      gpr_w_data_o = inst_data_i;
    end
  end

  assign err_set = (dir_v_i & ~q_v)
                 | (inst_v_i & (($countones(inst_gpr_w_i) > 1)
                              | (inst_dir_rd_i & ($countones(inst_dir_dst_i) > 1))));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_r <= '0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_eff | (push ? inst_dir_dst_i : '0);
      err_r  <= err_r | err_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle: if (push) state_n = e_wait;
      e_wait: if (dir_pop && (q_cnt == cnt_w'(1)) && !push) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_comb begin
    dir_idle_o = (state_r == e_idle);
  end

  assign gpr_busy_o = busy_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_bp_cce_gpr_wr_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_bp_cce_gpr_wr_sched;

  localparam int NG   = 8;
  localparam int GW   = 64;
  localparam int TAGS = 2;
  localparam int VW   = 1 + NG + GW + NG + 1 + 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          inst_v = 1'b0, inst_dir_rd = 1'b0, dir_v = 1'b0;
  logic [NG-1:0] inst_gpr_w = '0, inst_src = '0, inst_dst = '0;
  logic [GW-1:0] inst_data = '0, dir_data = '0;
  logic          inst_ready_o, dir_idle_o, err_o;
  logic [NG-1:0] gpr_w_mask_o, gpr_busy_o;
  logic [GW-1:0] gpr_w_data_o;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: outstanding destination tags in issue order.
  logic [NG-1:0] mq[$];
  bit            m_err = 1'b0;
  bit            e_ready, e_idle;
  logic [NG-1:0] e_mask, e_busy;
  logic [GW-1:0] e_data;

  wire [VW-1:0] obs = {inst_ready_o, gpr_w_mask_o, gpr_w_data_o, gpr_busy_o, dir_idle_o, err_o};

  always #5 clk = ~clk;

  bp_cce_gpr_wr_sched #(.num_gpr_p(NG), .gpr_width_p(GW), .dir_tags_p(TAGS)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .inst_v_i        (inst_v),
    .inst_gpr_w_i    (inst_gpr_w),
    .inst_src_mask_i (inst_src),
    .inst_dir_rd_i   (inst_dir_rd),
    .inst_dir_dst_i  (inst_dst),
    .inst_data_i     (inst_data),
    .inst_ready_o    (inst_ready_o),
    .dir_v_i         (dir_v),
    .dir_data_i      (dir_data),
    .gpr_w_mask_o    (gpr_w_mask_o),
    .gpr_w_data_o    (gpr_w_data_o),
    .gpr_busy_o      (gpr_busy_o),
    .dir_idle_o      (dir_idle_o),
    .err_o           (err_o)
  );

  function automatic void model_eval();
    logic [NG-1:0] head_eff, beff;
    bit st;
    e_busy = '0;
    foreach (mq[i]) e_busy |= mq[i];
    head_eff = (dir_v && mq.size() > 0) ? mq[0] : '0;
    beff     = e_busy & ~head_eff;
    st = (dir_v && inst_gpr_w != 0) || ((inst_src & beff) != 0) || ((inst_gpr_w & beff) != 0)
       || (inst_dir_rd && (inst_dst & beff) != 0) || (inst_dir_rd && mq.size() == TAGS && !dir_v);
    e_ready = inst_v && !st;
    if (dir_v) begin
      e_mask = head_eff; e_data = dir_data;
    end else if (e_ready) begin
      e_mask = inst_gpr_w; e_data = inst_data;
    end else begin
      e_mask = '0; e_data = '0;
    end
    e_idle = (mq.size() == 0);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_ready, e_mask, e_data, e_busy, e_idle, m_err};
  endfunction

  function automatic void model_update();
    if (reset_i) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (dir_v) begin
        if (mq.size() == 0) m_err = 1'b1;
        else void'(mq.pop_front());
      end
      if (inst_v && (($countones(inst_gpr_w) > 1) || (inst_dir_rd && $countones(inst_dst) > 1)))
        m_err = 1'b1;
      if (e_ready && inst_dir_rd) mq.push_back(inst_dst);
    end
  endfunction

  task automatic drive(input bit v, input logic [NG-1:0] w, input logic [NG-1:0] src,
                       input bit rd, input logic [NG-1:0] dst, input logic [GW-1:0] d,
                       input bit dv, input logic [GW-1:0] dd);
    inst_v = v; inst_gpr_w = w; inst_src = src; inst_dir_rd = rd; inst_dst = dst;
    inst_data = d; dir_v = dv; dir_data = dd;
    #2;
    model_eval();
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle(); tick();
    idle(); tick();
    reset_i = 1'b0;
    idle();
    n_total++; if (gpr_w_mask_o !== '0) $display("FAIL reset_mask got %h exp 00", gpr_w_mask_o); else n_pass++;
    n_total++; if (gpr_busy_o !== '0) $display("FAIL reset_busy got %h exp 00", gpr_busy_o); else n_pass++;
    n_total++; if (dir_idle_o !== 1'b1) $display("FAIL reset_idle got %b exp 1", dir_idle_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", err_o); else n_pass++;
    n_total++; if (inst_ready_o !== 1'b0) $display("FAIL reset_ready got %b exp 0", inst_ready_o); else n_pass++;
    tick();
  endtask

  task automatic test_inst_write();
    drive(1, 8'h08, '0, 0, '0, 64'h55, 0, '0);
    n_total++; if (gpr_w_mask_o !== 8'h08) $display("FAIL wr_mask got %h exp 08", gpr_w_mask_o); else n_pass++;
    n_total++; if (gpr_w_data_o !== 64'h55) $display("FAIL wr_data got %h exp 55", gpr_w_data_o); else n_pass++;
    n_total++; if (inst_ready_o !== 1'b1) $display("FAIL wr_ready got %b exp 1", inst_ready_o); else n_pass++;
    tick();
  endtask

  task automatic test_raw_bypass();
    drive(1, '0, '0, 1, 8'h04, '0, 0, '0);
    n_total++; if (inst_ready_o !== 1'b1) $display("FAIL rde_accept got %b exp 1", inst_ready_o); else n_pass++;
    tick();
    drive(1, '0, 8'h04, 0, '0, '0, 0, '0);
    n_total++; if (inst_ready_o !== 1'b0) $display("FAIL raw_stall got %b exp 0", inst_ready_o); else n_pass++;
    n_total++; if (gpr_busy_o !== 8'h04) $display("FAIL raw_busy got %h exp 04", gpr_busy_o); else n_pass++;
    tick();
    drive(1, '0, 8'h04, 0, '0, '0, 1, 64'h1000);
    n_total++; if (gpr_w_mask_o !== 8'h04) $display("FAIL byp_mask got %h exp 04", gpr_w_mask_o); else n_pass++;
    n_total++; if (gpr_w_data_o !== 64'h1000) $display("FAIL byp_data got %h exp 1000", gpr_w_data_o); else n_pass++;
    n_total++; if (inst_ready_o !== 1'b1) $display("FAIL byp_ready got %b exp 1", inst_ready_o); else n_pass++;
    tick();
    idle();
    n_total++; if (obs !== exp_vec()) $display("FAIL byp_after got %h exp %h", obs, exp_vec()); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, '0, '0, 1, 8'h02, '0, 0, '0); tick();
    drive(1, '0, '0, 1, 8'h10, '0, 0, '0); tick();
    drive(1, '0, '0, 1, 8'h40, '0, 0, '0);
    n_total++; if (inst_ready_o !== 1'b0) $display("FAIL full_stall got %b exp 0", inst_ready_o); else n_pass++;
    n_total++; if (gpr_busy_o !== 8'h12) $display("FAIL full_busy got %h exp 12", gpr_busy_o); else n_pass++;
    tick();
    drive(1, '0, '0, 1, 8'h40, '0, 1, 64'hA);
    n_total++; if (gpr_w_mask_o !== 8'h02) $display("FAIL ret1_mask got %h exp 02", gpr_w_mask_o); else n_pass++;
    n_total++; if (inst_ready_o !== 1'b1) $display("FAIL popfull_ready got %b exp 1", inst_ready_o); else n_pass++;
    tick();
    drive(0, '0, '0, 0, '0, '0, 1, 64'hB);
    n_total++; if (gpr_w_mask_o !== 8'h10) $display("FAIL ret2_mask got %h exp 10", gpr_w_mask_o); else n_pass++;
    tick();
    drive(0, '0, '0, 0, '0, '0, 1, 64'hC);
    n_total++; if (gpr_w_mask_o !== 8'h40) $display("FAIL ret3_mask got %h exp 40", gpr_w_mask_o); else n_pass++;
    tick();
    idle();
    n_total++; if (dir_idle_o !== 1'b1) $display("FAIL drain_idle got %b exp 1", dir_idle_o); else n_pass++;
    n_total++; if (obs !== exp_vec()) $display("FAIL drain_all got %h exp %h", obs, exp_vec()); else n_pass++;
    tick();
  endtask

  task automatic test_port_conflict();
    drive(1, '0, '0, 1, 8'h01, '0, 0, '0); tick();
    drive(1, 8'h20, '0, 0, '0, 64'h77, 1, 64'h2000);
    n_total++; if (gpr_w_mask_o !== 8'h01) $display("FAIL pc_mask got %h exp 01", gpr_w_mask_o); else n_pass++;
    n_total++; if (inst_ready_o !== 1'b0) $display("FAIL pc_stall got %b exp 0", inst_ready_o); else n_pass++;
    tick();
    drive(1, 8'h20, '0, 0, '0, 64'h77, 0, '0);
    n_total++; if (gpr_w_mask_o !== 8'h20) $display("FAIL pc_retry_mask got %h exp 20", gpr_w_mask_o); else n_pass++;
    n_total++; if (gpr_w_data_o !== 64'h77) $display("FAIL pc_retry_data got %h exp 77", gpr_w_data_o); else n_pass++;
    tick();
  endtask

  task automatic test_err_reset();
    drive(0, '0, '0, 0, '0, '0, 1, 64'h3);
    n_total++; if (gpr_w_mask_o !== '0) $display("FAIL err_mask got %h exp 00", gpr_w_mask_o); else n_pass++;
    tick();
    idle(); tick();
    idle();
    n_total++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_o); else n_pass++;
    drive(1, '0, '0, 1, 8'h80, '0, 0, '0); tick();
    reset_i = 1'b1; idle(); tick();
    reset_i = 1'b0; idle();
    n_total++; if (gpr_busy_o !== '0) $display("FAIL rst_busy got %h exp 00", gpr_busy_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", err_o); else n_pass++;
    n_total++; if (dir_idle_o !== 1'b1) $display("FAIL rst_idle got %b exp 1", dir_idle_o); else n_pass++;
    drive(0, '0, '0, 0, '0, '0, 1, 64'h9); tick();
    idle();
    n_total++; if (err_o !== 1'b1) $display("FAIL late_err got %b exp 1", err_o); else n_pass++;
    drive(1, 8'h03, '0, 0, '0, '0, 0, '0);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    drive(1, 8'h03, '0, 0, '0, '0, 0, '0); tick();
    idle();
    n_total++; if (err_o !== 1'b1) $display("FAIL multihot_err got %b exp 1", err_o); else n_pass++;
    reset_i = 1'b1; tick(); reset_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      bit            v, rd, dv;
      logic [NG-1:0] w, src, dst;
      v   = ($urandom_range(9) < 7);
      w   = ($urandom_range(2) == 0) ? (8'h01 << $urandom_range(7)) : '0;
      if (v && $urandom_range(149) == 0) w = 8'h03 << $urandom_range(6);
      src = ($urandom_range(1) == 0) ? (8'h01 << $urandom_range(7)) : '0;
      rd  = ($urandom_range(2) == 0);
      dst = 8'h01 << $urandom_range(7);
      dv  = (mq.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(99) == 0);
      reset_i = ($urandom_range(299) == 0);
      drive(v, w, src, rd, dst, {$urandom, $urandom}, dv, {$urandom, $urandom});
      n_total++;
      if (obs !== exp_vec()) $display("FAIL rand_%0d got %h exp %h", i, obs, exp_vec());
      else n_pass++;
      tick();
    end
    reset_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inst_write();
    test_raw_bypass();
    test_back_to_back();
    test_port_conflict();
    test_err_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
